// File: rtl/l2_bank_init_master_if.sv
// rtl/l2_bank_init_master_if.sv - TCDM request/response bundle between L2 initiator and target
interface l2_bank_init_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] add;
  logic                  wen;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic                  gnt;
  logic                  r_valid;
  logic [31:0]           r_rdata;

  modport master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata
  );
endinterface

// File: rtl/l2_bank_init_master.sv
// rtl/l2_bank_init_master.sv - TCDM initiator that pattern-fills an L2 window and optionally reads it back
// Read-back check and error outputs are built only when L2_INIT_VERIFY_EN is defined.
module l2_bank_init_master #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = ADDR_WIDTH'(32'h1C00_0000),
  parameter int                    NB_WORDS      = 8192,
  parameter int                    ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [31:0]              pattern_i,
  input  logic                     incr_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [ADDR_WIDTH-1:0]    first_err_addr_o,
  l2_bank_init_master_if.master    tcdm
);

  localparam int               IDX_W    = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WRITE, VERIFY_REQ, VERIFY_WAIT, DONE} state_e;

  state_e           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [31:0]      pattern_q, pattern_nxt;
  logic             incr_q, incr_nxt;
  logic             start_ok;

  logic                  req_d, wen_d;
  logic [3:0]            be_d;
  logic [ADDR_WIDTH-1:0] add_d;
  logic [31:0]           wdata_d;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + (ADDR_WIDTH'(i) << 2);
  endfunction

  function automatic logic [31:0] fill_data(input logic [IDX_W-1:0] i,
                                            input logic [31:0] p, input logic inc);
    return inc ? p + 32'(i) : p;
  endfunction

  // Captured values bypass into the first request so it can issue in the cycle after start.
  assign start_ok    = (state == IDLE) && start_i;
  assign pattern_nxt = start_ok ? pattern_i : pattern_q;
  assign incr_nxt    = start_ok ? incr_i : incr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      idx       <= '0;
      pattern_q <= '0;
      incr_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      pattern_q <= pattern_nxt;
      incr_q    <= incr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = WRITE;
          idx_nxt   = '0;
        end
      end
      WRITE: begin
        if (tcdm.req && tcdm.gnt) begin
          if (idx != LAST_IDX) begin
            idx_nxt = idx + IDX_W'(1);
          end else begin
`ifdef L2_INIT_VERIFY_EN
            state_nxt = VERIFY_REQ;
            idx_nxt   = '0;
`else
            state_nxt = DONE;
`endif
          end
        end
      end
`ifdef L2_INIT_VERIFY_EN
      VERIFY_REQ: begin
        if (tcdm.gnt) state_nxt = VERIFY_WAIT;
      end
      VERIFY_WAIT: begin
        if (tcdm.r_valid) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = VERIFY_REQ;
          end
        end
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state, so a stalled request holds its fields.
  always_comb begin
    req_d   = 1'b0;
    be_d    = 4'h0;
    add_d   = tcdm.add;
    wdata_d = tcdm.wdata;
`ifdef L2_INIT_VERIFY_EN
    wen_d   = 1'b1;
`else
    wen_d   = (state_nxt == IDLE);
`endif
    unique case (state_nxt)
      WRITE: begin
        req_d   = 1'b1;
        wen_d   = 1'b0;
        be_d    = 4'hF;
        add_d   = word_addr(idx_nxt);
        wdata_d = fill_data(idx_nxt, pattern_nxt, incr_nxt);
      end
      VERIFY_REQ: begin
        req_d = 1'b1;
        wen_d = 1'b1;
        be_d  = 4'hF;
        add_d = word_addr(idx_nxt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcdm.req   <= 1'b0;
      tcdm.add   <= '0;
      tcdm.wen   <= 1'b1;
      tcdm.wdata <= '0;
      tcdm.be    <= 4'h0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      tcdm.req   <= req_d;
      tcdm.add   <= add_d;
      tcdm.wen   <= wen_d;
      tcdm.wdata <= wdata_d;
      tcdm.be    <= be_d;
      busy_o     <= (state_nxt != IDLE);
      done_o     <= (state_nxt == DONE);
    end
  end

`ifdef L2_INIT_VERIFY_EN
  logic mismatch;

  assign mismatch = (state == VERIFY_WAIT) && tcdm.r_valid &&
                    (tcdm.r_rdata != fill_data(idx, pattern_q, incr_q));

  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      err_o            <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else if (mismatch) begin
      err_o <= 1'b1;
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
      if (!err_o) first_err_addr_o <= word_addr(idx);
    end
  end
`else
  logic unused_rsp;

  assign unused_rsp       = ^{tcdm.r_valid, tcdm.r_rdata};
  assign err_o            = 1'b0;
  assign err_cnt_o        = '0;
  assign first_err_addr_o = '0;
`endif

endmodule
